// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes and datapath selects.
package control_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    FAULT
  } state_t;

  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] ResAlu = 2'b00;
  localparam logic [1:0] ResMem = 2'b01;
  localparam logic [1:0] ResPc4 = 2'b10;

  // funct7[5] selects SUB only for register-register ops.
  function automatic logic [2:0] alu_decode(input logic [2:0] funct3, input logic is_op,
                                            input logic funct7_b5);
    logic [2:0] op;
    op = AluAdd;
    case (funct3)
      3'b000:  op = (is_op && funct7_b5) ? AluSub : AluAdd;
      3'b111:  op = AluAnd;
      3'b110:  op = AluOr;
      3'b100:  op = AluXor;
      3'b010:  op = AluSlt;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

  function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OpcOp, OpcOpImm: ok = (funct3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111});
      OpcLoad, OpcStore, OpcJal: ok = 1'b1;
      OpcBranch: ok = (funct3 == 3'b000) || (funct3 == 3'b001);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts memory wait cycles; expired flags the wait cycle that reaches MEM_TIMEOUT.
module wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && (cnt_q != CntMax)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires during the MEM_TIMEOUT-th consecutive wait so the FSM leaves on that edge.
  assign expired = (MEM_TIMEOUT != 0) && count && (cnt_q == CntLast);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FSM sequencing fetch/decode/execute/memory/writeback, with sticky fault on
// illegal opcodes or memory timeouts.
module multicycle_control
  import control_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned ALU_CTRL_WIDTH = 3,
  parameter int unsigned MEM_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDRESS_WIDTH-1:0]  instr,
  input  logic                      zero,
  input  logic                      mem_ready,
  output logic                      mem_req,
  output logic                      MemWrite,
  output logic                      IRWrite,
  output logic                      PCWrite,
  output logic                      PCsrc,
  output logic                      RegWrite,
  output logic                      ALUsrc,
  output logic [ALU_CTRL_WIDTH-1:0] ALUctrl,
  output logic [1:0]                ImmSrc,
  output logic [1:0]                ResultSrc,
  output logic                      retire,
  output logic                      fault
);

  state_t     state_q, state_d;
  logic       waiting, expired;
  logic [2:0] alu_op;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       is_op, is_arith, is_store;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];
  assign is_op     = (opcode == OpcOp);
  assign is_arith  = is_op || (opcode == OpcOpImm);
  assign is_store  = (opcode == OpcStore);

  logic unused_instr;
  assign unused_instr = ^{instr[ADDRESS_WIDTH-1:31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_d != state_q),
    .count  (waiting),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    waiting   = 1'b0;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ALUsrc    = 1'b0;
    alu_op    = AluAdd;
    ImmSrc    = ImmI;
    ResultSrc = ResAlu;
    retire    = 1'b0;
    fault     = 1'b0;

    unique case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end else begin
          waiting = 1'b1;
          if (expired) state_d = FAULT;
        end
      end
      DECODE: state_d = is_legal(opcode, funct3) ? EXECUTE : FAULT;
      EXECUTE: begin
        case (opcode)
          OpcOp, OpcOpImm: begin
            ALUsrc  = !is_op;
            alu_op  = alu_decode(funct3, is_op, funct7_b5);
            state_d = WRITEBACK;
          end
          OpcLoad, OpcStore: begin
            ALUsrc  = 1'b1;
            ImmSrc  = is_store ? ImmS : ImmI;
            state_d = MEMORY;
          end
          OpcBranch: begin
            alu_op  = AluSub;
            ImmSrc  = ImmB;
            PCsrc   = 1'b1;
            PCWrite = funct3[0] ? !zero : zero;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OpcJal: begin
            PCWrite = 1'b1;
            PCsrc   = 1'b1;
            ImmSrc  = ImmJ;
            state_d = WRITEBACK;
          end
          default: state_d = FAULT;
        endcase
      end
      MEMORY: begin
        mem_req  = 1'b1;
        MemWrite = is_store;
        ALUsrc   = 1'b1;
        ImmSrc   = is_store ? ImmS : ImmI;
        if (mem_ready) begin
          retire  = is_store;
          state_d = is_store ? FETCH : WRITEBACK;
        end else begin
          waiting = 1'b1;
          if (expired) state_d = FAULT;
        end
      end
      WRITEBACK: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
        if (is_arith) begin
          ALUsrc = !is_op;
          alu_op = alu_decode(funct3, is_op, funct7_b5);
        end
        if (opcode == OpcLoad)     ResultSrc = ResMem;
        else if (opcode == OpcJal) ResultSrc = ResPc4;
      end
      FAULT: fault = 1'b1;
      default: state_d = FAULT;
    endcase

    // Reset holds the state at FETCH, so every output must be masked directly.
    if (rst) begin
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCsrc     = 1'b0;
      RegWrite  = 1'b0;
      ALUsrc    = 1'b0;
      alu_op    = AluAdd;
      ImmSrc    = ImmI;
      ResultSrc = ResAlu;
      retire    = 1'b0;
      fault     = 1'b0;
    end
  end

  assign ALUctrl = ALU_CTRL_WIDTH'(alu_op);

endmodule
